// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard, forwarding and flush controller for the in-order pipeline.
//  - Detects EX-stage load-use hazards against the ID instruction.
//  - Tracks outstanding variable-latency loads in a per-register scoreboard
//    and stalls ID consumers of a busy register.
//  - Produces EX operand forwarding selects (EX/MEM has priority over MEM/WB).
//  - Flushes IF/ID and ID/EX on a taken branch; a taken branch overrides any
//    stall so the redirect is not lost.
//  - Counts stall cycles in a saturating counter for performance monitoring.
//
// Ports
//  clk, rst_n                       clock, asynchronous active-low reset
//  i_id_valid                       IF/ID holds a valid instruction
//  i_id_rs1/rs2, i_id_rs1/rs2_used  ID sources and whether they are read
//  i_ex_valid, i_ex_memread, i_ex_rd  ID/EX valid, is-load, destination
//  i_ex_rs1, i_ex_rs2               ID/EX sources (forwarding compare)
//  i_mem_regwrite, i_mem_rd         EX/MEM writeback info
//  i_wb_regwrite, i_wb_rd           MEM/WB writeback info
//  i_ld_issue, i_ld_issue_rd        load accepted by the memory interface
//  i_ld_done, i_ld_done_rd          load data returned and written
//  i_branch_taken                   EX resolved a taken branch/jump
//  i_stat_clr                       synchronous clear of the stall counter
//  o_pc_write, o_if_id_write        stage enables
//  o_if_id_flush, o_id_ex_flush     bubble insertion
//  o_fwd_a, o_fwd_b                 00 regfile, 01 MEM/WB, 10 EX/MEM
//  o_busy_vec                       scoreboard state, one bit per register
//  o_stall_count                    saturating stall-cycle count
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_HW = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_id_valid,
    input  logic [REG_AW-1:0]        i_id_rs1,
    input  logic [REG_AW-1:0]        i_id_rs2,
    input  logic                     i_id_rs1_used,
    input  logic                     i_id_rs2_used,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_memread,
    input  logic [REG_AW-1:0]        i_ex_rd,
    input  logic [REG_AW-1:0]        i_ex_rs1,
    input  logic [REG_AW-1:0]        i_ex_rs2,
    input  logic                     i_mem_regwrite,
    input  logic [REG_AW-1:0]        i_mem_rd,
    input  logic                     i_wb_regwrite,
    input  logic [REG_AW-1:0]        i_wb_rd,
    input  logic                     i_ld_issue,
    input  logic [REG_AW-1:0]        i_ld_issue_rd,
    input  logic                     i_ld_done,
    input  logic [REG_AW-1:0]        i_ld_done_rd,
    input  logic                     i_branch_taken,
    input  logic                     i_stat_clr,
    output logic                     o_pc_write,
    output logic                     o_if_id_write,
    output logic                     o_if_id_flush,
    output logic                     o_id_ex_flush,
    output logic [1:0]               o_fwd_a,
    output logic [1:0]               o_fwd_b,
    output logic [(1<<REG_AW)-1:0]   o_busy_vec,
    output logic [STALL_CNT_W-1:0]   o_stall_count
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // An address may take part in a match only if it is not the hardwired
    // zero register (when that option is enabled).
    function automatic logic addr_ok(input logic [REG_AW-1:0] a);
        return (ZERO_REG_HW == 0) || (a != '0);
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            logic w_set;
            logic w_clr;
            assign w_set = i_ld_issue && (i_ld_issue_rd == REG_AW'(gi))
                           && addr_ok(REG_AW'(gi));
            assign w_clr = i_ld_done && (i_ld_done_rd == REG_AW'(gi));
            // Issue and completion on the same register in one cycle means a
            // new load is now outstanding, so set beats clear.
            assign w_busy_next[gi] = w_set ? 1'b1 :
                                     w_clr ? 1'b0 : r_busy[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy_vec = r_busy;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ex_load;
    logic w_load_use;
    logic w_sb_hazard;
    logic w_stall;

    assign w_rs1_hit = i_id_valid && i_id_rs1_used && addr_ok(i_id_rs1);
    assign w_rs2_hit = i_id_valid && i_id_rs2_used && addr_ok(i_id_rs2);

    assign w_ex_load  = i_ex_valid && i_ex_memread;
    assign w_load_use = w_ex_load &&
                        ((w_rs1_hit && (i_ex_rd == i_id_rs1)) ||
                         (w_rs2_hit && (i_ex_rd == i_id_rs2)));

    // Uses the registered busy bit only: a load completing this cycle
    // releases its consumer one cycle later, keeping this path short.
    assign w_sb_hazard = (w_rs1_hit && r_busy[i_id_rs1]) ||
                         (w_rs2_hit && r_busy[i_id_rs2]);

    // The taken branch squashes the stalled ID instruction anyway, so the
    // front end must keep moving to fetch the redirect target.
    assign w_stall = (w_load_use || w_sb_hazard) && !i_branch_taken;

    assign o_pc_write    = !w_stall;
    assign o_if_id_write = !w_stall;
    assign o_id_ex_flush = w_stall || i_branch_taken;
    assign o_if_id_flush = i_branch_taken;

    // -----------------------------------------------------------------------
    // Forwarding
    // -----------------------------------------------------------------------
    logic w_mem_ok;
    logic w_wb_ok;

    assign w_mem_ok = i_mem_regwrite && addr_ok(i_mem_rd);
    assign w_wb_ok  = i_wb_regwrite && addr_ok(i_wb_rd);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        o_fwd_a = FWD_RF;
        if (w_mem_ok && (i_mem_rd == i_ex_rs1)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_wb_ok && (i_wb_rd == i_ex_rs1)) begin
            o_fwd_a = FWD_WB;
        end
    end

    always_comb begin
        o_fwd_b = FWD_RF;
        if (w_mem_ok && (i_mem_rd == i_ex_rs2)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_wb_ok && (i_wb_rd == i_ex_rs2)) begin
            o_fwd_b = FWD_WB;
        end
    end

    // -----------------------------------------------------------------------
    // Stall-cycle counter
    // -----------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    localparam int REG_AW      = 3;
    localparam int ZERO_REG_HW = 1;
    localparam int STALL_CNT_W = 4;
    localparam int NREG        = 1 << REG_AW;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_rs1_used, id_rs2_used;
    logic              ex_valid, ex_memread;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              ld_issue;
    logic [REG_AW-1:0] ld_issue_rd;
    logic              ld_done;
    logic [REG_AW-1:0] ld_done_rd;
    logic              branch_taken;
    logic              stat_clr;
    logic              pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic [NREG-1:0]   busy_vec;
    logic [STALL_CNT_W-1:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .ZERO_REG_HW(ZERO_REG_HW), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
        .i_ex_valid(ex_valid), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
        .i_mem_regwrite(mem_regwrite), .i_mem_rd(mem_rd),
        .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd),
        .i_ld_issue(ld_issue), .i_ld_issue_rd(ld_issue_rd),
        .i_ld_done(ld_done), .i_ld_done_rd(ld_done_rd),
        .i_branch_taken(branch_taken), .i_stat_clr(stat_clr),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_busy_vec(busy_vec), .o_stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1-3 ns after
    // the rising edge, well away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_valid = 0; ex_memread = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
        ld_issue = 0; ld_issue_rd = 0; ld_done = 0; ld_done_rd = 0;
        branch_taken = 0; stat_clr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        settle();
        n_total++;
        if (busy_vec !== 8'h00) $display("FAIL reset_busy actual=%h required=00", busy_vec);
        else n_pass++;
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL reset_count actual=%0d required=0", stall_count);
        else n_pass++;
        n_total++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100)
            $display("FAIL reset_ctrl actual=%b required=1100",
                     {pc_write, if_id_write, if_id_flush, id_ex_flush});
        else n_pass++;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reset_fwd actual=%b required=0000", {fwd_a, fwd_b});
        else n_pass++;
        $display("test_reset done: busy=%h count=%0d", busy_vec, stall_count);
    endtask

    task automatic test_load_use();
        step();
        ex_valid = 1; ex_memread = 1; ex_rd = 3;
        id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
        settle();
        n_total++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001)
            $display("FAIL load_use_ctrl actual=%b required=0001",
                     {pc_write, if_id_write, if_id_flush, id_ex_flush});
        else n_pass++;
        step();
        clear_inputs();
        settle();
        n_total++;
        if (stall_count !== 4'd1) $display("FAIL load_use_count actual=%0d required=1", stall_count);
        else n_pass++;
        // rs unused: no hazard even with matching address
        ex_valid = 1; ex_memread = 1; ex_rd = 3;
        id_valid = 1; id_rs1 = 3; id_rs1_used = 0;
        settle();
        n_total++;
        if (pc_write !== 1'b1) $display("FAIL load_use_unused actual=%b required=1", pc_write);
        else n_pass++;
        // zero register never hazards
        ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        settle();
        n_total++;
        if ({pc_write, id_ex_flush} !== 2'b10)
            $display("FAIL load_use_zero actual=%b required=10", {pc_write, id_ex_flush});
        else n_pass++;
        step();
        clear_inputs();
        settle();
        n_total++;
        if (stall_count !== 4'd1) $display("FAIL load_use_zero_count actual=%0d required=1", stall_count);
        else n_pass++;
        $display("test_load_use done: count=%0d", stall_count);
    endtask

    task automatic test_scoreboard();
        stat_clr = 1;
        step();
        stat_clr = 0;
        ld_issue = 1; ld_issue_rd = 5;
        step();
        ld_issue = 0;
        settle();
        n_total++;
        if (busy_vec !== 8'h20) $display("FAIL sb_set actual=%h required=20", busy_vec);
        else n_pass++;
        id_valid = 1; id_rs2 = 5; id_rs2_used = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                ld_done = 1; ld_done_rd = 5;
            end
            settle();
            n_total++;
            if ({pc_write, if_id_write, id_ex_flush} !== 3'b001)
                $display("FAIL sb_stall_c%0d actual=%b required=001", c,
                         {pc_write, if_id_write, id_ex_flush});
            else n_pass++;
            step();
        end
        ld_done = 0;
        settle();
        n_total++;
        if ({pc_write, id_ex_flush, busy_vec} !== {2'b10, 8'h00})
            $display("FAIL sb_release actual=%b/%h required=10/00", {pc_write, id_ex_flush}, busy_vec);
        else n_pass++;
        n_total++;
        if (stall_count !== 4'd4) $display("FAIL sb_count actual=%0d required=4", stall_count);
        else n_pass++;
        clear_inputs();
        // simultaneous issue and done on the same register: set wins
        ld_issue = 1; ld_issue_rd = 5; ld_done = 1; ld_done_rd = 5;
        step();
        // different registers: both apply
        ld_issue = 1; ld_issue_rd = 6; ld_done = 1; ld_done_rd = 5;
        settle();
        n_total++;
        if (busy_vec !== 8'h20) $display("FAIL sb_same_cycle actual=%h required=20", busy_vec);
        else n_pass++;
        step();
        // zero register never becomes busy
        ld_issue = 1; ld_issue_rd = 0; ld_done = 1; ld_done_rd = 6;
        settle();
        n_total++;
        if (busy_vec !== 8'h40) $display("FAIL sb_diff_regs actual=%h required=40", busy_vec);
        else n_pass++;
        step();
        clear_inputs();
        settle();
        n_total++;
        if (busy_vec !== 8'h00) $display("FAIL sb_zero_reg actual=%h required=00", busy_vec);
        else n_pass++;
        $display("test_scoreboard done: busy=%h count=%0d", busy_vec, stall_count);
    endtask

    task automatic test_branch_override();
        ex_valid = 1; ex_memread = 1; ex_rd = 3;
        id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
        branch_taken = 1;
        settle();
        n_total++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111)
            $display("FAIL branch_ctrl actual=%b required=1111",
                     {pc_write, if_id_write, if_id_flush, id_ex_flush});
        else n_pass++;
        step();
        clear_inputs();
        settle();
        n_total++;
        if (stall_count !== 4'd4) $display("FAIL branch_count actual=%0d required=4", stall_count);
        else n_pass++;
        $display("test_branch_override done: count=%0d", stall_count);
    endtask

    task automatic test_forwarding();
        ex_rs1 = 2; mem_rd = 2; wb_rd = 2; mem_regwrite = 1; wb_regwrite = 1;
        settle();
        n_total++;
        if (fwd_a !== 2'b10) $display("FAIL fwd_a_mem actual=%b required=10", fwd_a);
        else n_pass++;
        mem_regwrite = 0;
        settle();
        n_total++;
        if (fwd_a !== 2'b01) $display("FAIL fwd_a_wb actual=%b required=01", fwd_a);
        else n_pass++;
        ex_rs2 = 0; wb_rd = 0; mem_rd = 0; mem_regwrite = 1;
        settle();
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL fwd_zero actual=%b required=0000", {fwd_a, fwd_b});
        else n_pass++;
        ex_rs1 = 7; ex_rs2 = 4; mem_rd = 7; wb_rd = 4;
        settle();
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b1001) $display("FAIL fwd_split actual=%b required=1001", {fwd_a, fwd_b});
        else n_pass++;
        clear_inputs();
        $display("test_forwarding done");
    endtask

    task automatic test_saturation();
        stat_clr = 1;
        step();
        stat_clr = 0;
        ex_valid = 1; ex_memread = 1; ex_rd = 3;
        id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
        for (int c = 1; c <= (1 << STALL_CNT_W) + 3; c++) begin
            step();
            if (c == 15 || c == 16) begin
                n_total++;
                if (stall_count !== 4'hF) $display("FAIL sat_c%0d actual=%0d required=15", c, stall_count);
                else n_pass++;
            end
        end
        settle();
        n_total++;
        if (stall_count !== 4'hF) $display("FAIL sat_final actual=%0d required=15", stall_count);
        else n_pass++;
        stat_clr = 1;
        step();
        stat_clr = 0;
        settle();
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL sat_clr actual=%0d required=0", stall_count);
        else n_pass++;
        step();
        n_total++;
        if (stall_count !== 4'd1) $display("FAIL sat_after_clr actual=%0d required=1", stall_count);
        else n_pass++;
        clear_inputs();
        $display("test_saturation done: count=%0d", stall_count);
    endtask

    task automatic test_reset_mid();
        ld_issue = 1; ld_issue_rd = 2;
        step();
        ld_issue = 0;
        settle();
        n_total++;
        if (busy_vec !== 8'h04) $display("FAIL rst_mid_pre actual=%h required=04", busy_vec);
        else n_pass++;
        rst_n = 0;
        #1;
        n_total++;
        if ({busy_vec, stall_count} !== {8'h00, 4'd0})
            $display("FAIL rst_mid actual=%h/%0d required=00/0", busy_vec, stall_count);
        else n_pass++;
        step();
        rst_n = 1;
        $display("test_reset_mid done: busy=%h", busy_vec);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_scoreboard();
        test_branch_override();
        test_forwarding();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
